// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between two requesting masters, the arbiter
// and a single-port word memory.
//   m0_*/m1_*  : per-master request (req/we/addr/wdata/wsize) and the
//                grant / read-valid pulses returned to it
//   m_rdata    : shared read data returned to both masters
//   mem_*      : memory-side address, strobes, write data/size and read data
// Modports: slave = arbiter side, master = masters + memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [1:0]        m0_wsize;
    logic              m0_gnt;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [1:0]        m1_wsize;
    logic              m1_gnt;
    logic              m1_rvalid;

    logic [DATA_W-1:0] m_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rstrb;
    logic              mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_wsize;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wsize,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wsize,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m_rdata,
        output mem_addr, mem_rstrb, mem_wstrb, mem_wdata, mem_wsize
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wsize,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wsize,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m_rdata,
        input  mem_addr, mem_rstrb, mem_wstrb, mem_wdata, mem_wsize
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port word memory.
// Accepts one request at a time, strobes the memory for exactly one cycle and
// returns read data with a one-cycle valid pulse. Ties resolve round-robin,
// or always to master 0 when FIXED_PRIO=1.
//   clk    : divided system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave (master requests, grants, memory port)
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    logic              win_q;
    logic              we_q;
    logic              last_winner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        wsize_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              rstrb_q;
    logic              wstrb_q;

    logic              win_c;
    logic              we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [1:0]        wsize_c;

    // Winner selection and request-field mux (only consumed in IDLE)
    always_comb begin
        win_c = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            win_c = FIXED_PRIO ? 1'b0 : ~last_winner;
        end else begin
            win_c = bus.m1_req;
        end
        we_c    = win_c ? bus.m1_we    : bus.m0_we;
        addr_c  = win_c ? bus.m1_addr  : bus.m0_addr;
        wdata_c = win_c ? bus.m1_wdata : bus.m0_wdata;
        wsize_c = win_c ? bus.m1_wsize : bus.m0_wsize;
    end

    // FSM with registered pulses; strobes are high only during ISSUE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            last_winner <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            wsize_q     <= 2'b00;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rstrb_q     <= 1'b0;
            wstrb_q     <= 1'b0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rstrb_q   <= 1'b0;
            wstrb_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        state       <= ISSUE;
                        win_q       <= win_c;
                        last_winner <= win_c;
                        we_q        <= we_c;
                        addr_q      <= addr_c;
                        wdata_q     <= wdata_c;
                        wsize_q     <= wsize_c;
                        gnt0_q      <= ~win_c;
                        gnt1_q      <= win_c;
                        rstrb_q     <= ~we_c;
                        wstrb_q     <= we_c;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        // memory registers read data at this edge
                        state     <= RESP;
                        rvalid0_q <= ~win_q;
                        rvalid1_q <= win_q;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m0_gnt    = gnt0_q;
    assign bus.m1_gnt    = gnt1_q;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m_rdata   = bus.mem_rdata;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wsize = wsize_q;
    assign bus.mem_rstrb = rstrb_q;
    assign bus.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. One round-robin instance
// with a byte-lane word memory model, one fixed-priority instance.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ba ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bf ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1'b0)) u_rr (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ba)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1'b1)) u_fix (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bf)
    );

    // Word memory with registered read and byte-lane writes
    logic [31:0] mem [0:4095];

    always @(posedge clk) begin
        if (ba.mem_wstrb) begin
            case (ba.mem_wsize)
                2'b01:   mem[ba.mem_addr[13:2]][{ba.mem_addr[1:0], 3'b000} +: 8]  = ba.mem_wdata[7:0];
                2'b10:   mem[ba.mem_addr[13:2]][{ba.mem_addr[1], 4'b0000} +: 16] = ba.mem_wdata[15:0];
                default: mem[ba.mem_addr[13:2]] = ba.mem_wdata;
            endcase
        end
        if (ba.mem_rstrb) begin
            ba.mem_rdata <= mem[ba.mem_addr[13:2]];
        end
    end

    assign bf.mem_rdata = 32'h0;

    int n_cmp    = 0;
    int n_err    = 0;
    int m1_cnt   = 0;
    int dual_cnt = 0;

    always @(negedge clk) begin
        if (ba.m1_gnt || ba.m1_rvalid) m1_cnt++;
        if ((ba.mem_rstrb && ba.mem_wstrb) || (bf.mem_rstrb && bf.mem_wstrb) ||
            (ba.m0_gnt && ba.m1_gnt) || (bf.m0_gnt && bf.m1_gnt)) dual_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input logic m, input logic req, input logic we,
                           input logic [13:0] addr, input logic [31:0] wdata,
                           input logic [1:0] wsize);
        if (!m) begin
            ba.m0_req = req; ba.m0_we = we; ba.m0_addr = addr;
            ba.m0_wdata = wdata; ba.m0_wsize = wsize;
        end else begin
            ba.m1_req = req; ba.m1_we = we; ba.m1_addr = addr;
            ba.m1_wdata = wdata; ba.m1_wsize = wsize;
        end
    endtask

    // Bounded wait for a grant on either instance; returns the granted master
    task automatic wait_gnt(input logic fix, output int who);
        logic [1:0] g;
        who = -1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            g = fix ? {bf.m1_gnt, bf.m0_gnt} : {ba.m1_gnt, ba.m0_gnt};
            if (g != 2'b00) begin
                who = g[1] ? 1 : 0;
                break;
            end
        end
        if (who < 0) chk("gnt_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_write(input logic m, input logic [13:0] addr, input logic [31:0] data);
        int who;
        set_req(m, 1'b1, 1'b1, addr, data, 2'b11);
        wait_gnt(1'b0, who);
        set_req(m, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc();
    endtask

    int exp_order [4] = '{0, 1, 0, 1};

    initial begin
        int who;
        int snap;
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        set_req(1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        bf.m0_req = 1'b0; bf.m0_we = 1'b0; bf.m0_addr = 14'h0; bf.m0_wdata = 32'h0; bf.m0_wsize = 2'b00;
        bf.m1_req = 1'b0; bf.m1_we = 1'b0; bf.m1_addr = 14'h0; bf.m1_wdata = 32'h0; bf.m1_wsize = 2'b00;

        // Reset state
        #1 resetn = 1'b0;
        #1;
        chk("rst_pulses", {28'h0, ba.m0_gnt, ba.m1_gnt, ba.m0_rvalid, ba.m1_rvalid}, 32'h0);
        chk("rst_strobes", {30'h0, ba.mem_rstrb, ba.mem_wstrb}, 32'h0);
        chk("rst_addr", {18'h0, ba.mem_addr}, 32'h0);
        chk("rst_wdata", ba.mem_wdata, 32'h0);
        chk("rst_wsize", {30'h0, ba.mem_wsize}, 32'h0);
        cyc(); cyc();
        resetn = 1'b1;

        // Test 1: master 0 word write then read
        snap = m1_cnt;
        set_req(1'b0, 1'b1, 1'b1, 14'h0010, 32'hDEADBEEF, 2'b11);
        cyc();
        chk("t1_wr_gnt", {31'h0, ba.m0_gnt}, 32'h1);
        chk("t1_wstrb", {31'h0, ba.mem_wstrb}, 32'h1);
        chk("t1_rstrb_low", {31'h0, ba.mem_rstrb}, 32'h0);
        chk("t1_addr", {18'h0, ba.mem_addr}, 32'h0010);
        chk("t1_wdata", ba.mem_wdata, 32'hDEADBEEF);
        chk("t1_wsize", {30'h0, ba.mem_wsize}, 32'h3);
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc();
        chk("t1_gnt_pulse", {31'h0, ba.m0_gnt}, 32'h0);
        chk("t1_wstrb_pulse", {31'h0, ba.mem_wstrb}, 32'h0);
        set_req(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 2'b11);
        cyc();
        chk("t1_rd_gnt", {31'h0, ba.m0_gnt}, 32'h1);
        chk("t1_rd_rstrb", {31'h0, ba.mem_rstrb}, 32'h1);
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc();
        chk("t1_rvalid", {31'h0, ba.m0_rvalid}, 32'h1);
        chk("t1_rdata", ba.m_rdata, 32'hDEADBEEF);
        cyc();
        chk("t1_rvalid_pulse", {31'h0, ba.m0_rvalid}, 32'h0);
        chk("t1_m1_quiet", 32'(m1_cnt - snap), 32'h0);

        // Test 2: preload, reset, then both masters read continuously
        do_write(1'b0, 14'h0000, 32'hA0A00000);
        do_write(1'b1, 14'h0004, 32'hB1B10004);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 14'h0000, 32'h0, 2'b11);
        set_req(1'b1, 1'b1, 1'b0, 14'h0004, 32'h0, 2'b11);
        for (int i = 0; i < 4; i++) begin
            wait_gnt(1'b0, who);
            chk("t2_order", 32'(who), 32'(exp_order[i]));
            cyc();
            if (exp_order[i] == 0) begin
                chk("t2_rvalid_m0", {30'h0, ba.m0_rvalid, ba.m1_rvalid}, 32'h2);
                chk("t2_rdata_m0", ba.m_rdata, 32'hA0A00000);
            end else begin
                chk("t2_rvalid_m1", {30'h0, ba.m0_rvalid, ba.m1_rvalid}, 32'h1);
                chk("t2_rdata_m1", ba.m_rdata, 32'hB1B10004);
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        set_req(1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc(); cyc();

        // Test 3: fixed priority, master 0 wins every tie
        bf.m0_req = 1'b1; bf.m0_we = 1'b1; bf.m0_addr = 14'h0100; bf.m0_wsize = 2'b11;
        bf.m1_req = 1'b1; bf.m1_we = 1'b1; bf.m1_addr = 14'h0200; bf.m1_wsize = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(1'b1, who);
            chk("t3_m0_wins", 32'(who), 32'h0);
        end
        bf.m0_req = 1'b0;
        wait_gnt(1'b1, who);
        chk("t3_m1_after", 32'(who), 32'h1);
        bf.m1_req = 1'b0;
        cyc(); cyc();

        // Test 4: master 1 byte write into lane 3
        do_write(1'b1, 14'h0020, 32'h00000000);
        set_req(1'b1, 1'b1, 1'b1, 14'h0023, 32'h000000AB, 2'b01);
        cyc();
        chk("t4_gnt", {30'h0, ba.m0_gnt, ba.m1_gnt}, 32'h1);
        chk("t4_wstrb", {31'h0, ba.mem_wstrb}, 32'h1);
        chk("t4_wsize", {30'h0, ba.mem_wsize}, 32'h1);
        chk("t4_addr", {18'h0, ba.mem_addr}, 32'h0023);
        set_req(1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc();
        chk("t4_wstrb_single", {31'h0, ba.mem_wstrb}, 32'h0);
        set_req(1'b0, 1'b1, 1'b0, 14'h0020, 32'h0, 2'b11);
        wait_gnt(1'b0, who);
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc();
        chk("t4_rvalid", {31'h0, ba.m0_rvalid}, 32'h1);
        chk("t4_rdata", ba.m_rdata, 32'hAB000000);
        cyc();

        // Test 5: master 1 requests while master 0's read is in flight
        set_req(1'b0, 1'b1, 1'b0, 14'h0000, 32'h0, 2'b11);
        cyc();
        chk("t5_m0_gnt", {31'h0, ba.m0_gnt}, 32'h1);
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        set_req(1'b1, 1'b1, 1'b0, 14'h0004, 32'h0, 2'b11);
        cyc();
        chk("t5_resp_m1_wait", {31'h0, ba.m1_gnt}, 32'h0);
        chk("t5_m0_rvalid", {31'h0, ba.m0_rvalid}, 32'h1);
        chk("t5_m0_rdata", ba.m_rdata, 32'hA0A00000);
        cyc();
        chk("t5_idle_m1_wait", {31'h0, ba.m1_gnt}, 32'h0);
        cyc();
        chk("t5_m1_gnt", {31'h0, ba.m1_gnt}, 32'h1);
        set_req(1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc();
        chk("t5_m1_rvalid", {31'h0, ba.m1_rvalid}, 32'h1);
        chk("t5_m1_rdata", ba.m_rdata, 32'hB1B10004);
        cyc();

        // Test 6: reset between edges while the read strobe is high
        set_req(1'b0, 1'b1, 1'b0, 14'h0000, 32'h0, 2'b11);
        cyc();
        chk("t6_rstrb_before", {31'h0, ba.mem_rstrb}, 32'h1);
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        #1 resetn = 1'b0;
        #1;
        chk("t6_async_rstrb", {31'h0, ba.mem_rstrb}, 32'h0);
        chk("t6_async_pulses", {28'h0, ba.m0_gnt, ba.m1_gnt, ba.m0_rvalid, ba.m1_rvalid}, 32'h0);
        cyc();
        chk("t6_no_rvalid", {30'h0, ba.m0_rvalid, ba.m1_rvalid}, 32'h0);
        resetn = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 14'h0000, 32'h0, 2'b11);
        set_req(1'b1, 1'b1, 1'b0, 14'h0004, 32'h0, 2'b11);
        wait_gnt(1'b0, who);
        chk("t6_first_tie", 32'(who), 32'h0);
        set_req(1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        set_req(1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 2'b00);
        cyc(); cyc(); cyc();

        chk("no_dual_strobe_or_gnt", 32'(dual_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter that shares the single-port 16 kB word memory between the CPU fetch/load-store port (master 0) and a second bus master, such as a firmware loader or DMA (master 1).
- Latches one request at a time and drives the memory strobe port for exactly one cycle.
- Returns read data with a valid pulse.
- Chooses a winner by round-robin, or by fixed priority when configured.
- Sits between the masters and the memory, on the divided CPU clock.

Parameters:
ADDR_W, 14, byte address width of the memory port
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins a tie

Ports:
clk  input  1  divided system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
m0_req  input  1  master 0 request; held with its fields until m0_gnt
m0_we  input  1  master 0 write (1) / read (0)
m0_addr  input  ADDR_W  master 0 byte address
m0_wdata  input  DATA_W  master 0 write data
m0_wsize  input  2  master 0 size: 01 byte, 10 half, 11 word
m0_gnt  output  1  one-cycle pulse: request accepted
m0_rvalid  output  1  one-cycle pulse: m_rdata is valid for master 0
m1_req, m1_we, m1_addr, m1_wdata, m1_wsize  input  same as master 0  master 1 request
m1_gnt, m1_rvalid  output  1  master 1 grant / read-valid
m_rdata  output  DATA_W  shared read data (mem_rdata passthrough)
mem_addr  output  ADDR_W  memory address
mem_rstrb  output  1  memory read strobe
mem_wstrb  output  1  memory write strobe
mem_wdata  output  DATA_W  memory write data
mem_wsize  output  2  memory write size
mem_rdata  input  DATA_W  memory read data (registered in memory, 1-cycle latency)

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE; all gnt, rvalid, mem_rstrb, mem_wstrb are 0.
  - mem_addr, mem_wdata and mem_wsize are 0; last_winner=1, so master 0 wins the first tie.
  - Outputs clear immediately, independent of clk.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick a winner: the sole requester; on a tie, master 0 when FIXED_PRIO=1, else !last_winner.
  - Latch winner id and we/addr/wdata/wsize into registers; update last_winner; go to ISSUE.
- ISSUE (exactly one cycle):
  - Memory drive: mem_addr/mem_wdata/mem_wsize come from the latches; mem_rstrb = !we_latched and mem_wstrb = we_latched.
  - Grant: gnt of the winner = 1 this cycle only.
  - Next state: write goes to IDLE; read goes to RESP.
- RESP (one cycle): rvalid of the winner = 1, m_rdata = mem_rdata (value registered by the memory at the end of ISSUE); go to IDLE.
- Latency from the req-sampling edge:
  - Write: gnt and wstrb in the next cycle; 2 cycles total per write.
  - Read: gnt and rstrb in the next cycle, rvalid one cycle later; 3 cycles total per read.
- Strobes are registered outputs: never combinational from req, never both high, never high outside ISSUE.
- Requests are ignored while not in IDLE. A master must hold req asserted until its gnt; it may deassert req in the gnt cycle. A req still high after gnt, sampled in the following IDLE cycle, is a new request.
- Round-robin fairness: with both requesting continuously, grants alternate 0,1,0,1…; no master waits more than one foreign transaction.
- m_rdata is don't-care outside an rvalid pulse.
- Reset mid-operation:
  - Reset asserted in ISSUE: the strobe drops asynchronously. Whether the memory completed the access is undefined, and that master sees no rvalid.
  - Reset asserted in RESP: the rvalid pulse is lost.
- Address, size and data are passed unchanged; the memory performs byte-lane handling.

Test Plan:
- Single write then read, master 0: m0 writes 0xDEADBEEF, wsize=11, addr 0x0010. Required: m0_gnt and mem_wstrb one cycle after the req edge. Read of 0x0010 returns m0_rvalid with m_rdata=0xDEADBEEF exactly 2 cycles after req sampling. m1_gnt and m1_rvalid stay 0 throughout.
- Simultaneous reads after reset, round-robin: both masters read continuously, m0 from 0x0000 and m1 from 0x0004. Required: grant order m0,m1,m0,m1; each rvalid goes to the correct master with that master's word.
- FIXED_PRIO=1, both requesting: master 0 wins every tie. Master 1 is granted only in an IDLE cycle where m0_req=0.
- Byte write from master 1: m1 writes 0xAB, wsize=01, addr 0x0023. Required: mem_wsize=01 and mem_addr=0x0023 during the single wstrb cycle; a word read of 0x0020 returns 0xAB in bits 31:24.
- Request during busy: m1_req rises while master 0's read is in ISSUE. Required: m1 is not granted until the cycle after RESP returns to IDLE, and is never dropped.
- Reset mid-ISSUE: resetn pulled low between edges while mem_rstrb=1. Required: mem_rstrb, gnt and rvalid go low without a clock edge. After release, the first tie goes to master 0.
